rsa_exp_seq: RTL and testbench
==============================

RSA_EXP_SEQ -- requirements
Module: rsa_exp_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 8, exponent bit width (legal 2..32).
REQ-002 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port en_rsa  input  1  enable; 0 freezes all state.
REQ-005 SHALL have port rst_rsa  input  1  active-low sequence clear; 1 = run.
REQ-006 SHALL have port exp_i  input  WIDTH  exponent, sampled in LOAD only.
REQ-007 SHALL have port mm_done  input  1  one-cycle multiplier completion pulse.
REQ-008 SHALL have port ld_one  output  1  one-cycle pulse: set accumulator to 1.
REQ-009 SHALL have port mm_start  output  1  one-cycle multiplier request pulse.
REQ-010 SHALL have port mm_sel  output  1  0 = square, 1 = multiply by base; valid with mm_start, held until mm_done.
REQ-011 SHALL have port bit_idx  output  $clog2(WIDTH)  current exponent bit index.
REQ-012 SHALL have port op_cnt  output  $clog2(2*WIDTH)+1  multiplier operations issued since LOAD.
REQ-013 SHALL have port eoc_int  output  1  end of exponentiation, level.

Function
REQ-014 SHALL implement left-to-right square-and-multiply: for i = WIDTH-1 downto 0, square, then multiply if exp bit i = 1.
REQ-015 SHALL use states IDLE, LOAD, SQ_REQ, SQ_WAIT, MUL_REQ, MUL_WAIT, NEXT, DONE.
REQ-016 SHALL transition IDLE->LOAD on the first enabled cycle with rst_rsa=1.
REQ-017 SHALL, in LOAD, latch exp_i, pulse ld_one, set bit_idx=WIDTH-1 and op_cnt=0; exp_i=0 -> DONE, else -> SQ_REQ.
REQ-018 SHALL, in SQ_REQ and MUL_REQ, assert mm_start for exactly one cycle, increment op_cnt, then enter the matching WAIT state.
REQ-019 SHALL leave SQ_WAIT on mm_done: to MUL_REQ if the latched bit at bit_idx is 1, else to NEXT; MUL_WAIT goes to NEXT on mm_done.
REQ-020 SHALL, in NEXT, go to DONE if bit_idx=0, else decrement bit_idx and go to SQ_REQ.
REQ-021 SHALL hold eoc_int=1 in DONE until rst_rsa=0; no other outputs are active in DONE.
REQ-022 SHALL ignore mm_done outside SQ_WAIT/MUL_WAIT and in the same cycle as mm_start.
REQ-023 SHALL, when en_rsa=0, freeze state, bit_idx, op_cnt and eoc_int, force mm_start and ld_one to 0, and ignore mm_done.
REQ-024 SHALL, when rst_rsa=0 and en_rsa=1, return to IDLE next cycle from any state (including a mid-operation WAIT) and clear op_cnt, bit_idx and eoc_int.
REQ-025 SHALL NOT re-issue a request after rst_rsa abort; a late mm_done in IDLE is ignored.

Reset
REQ-026 SHALL, when rst=1, go to IDLE with all outputs 0, bit_idx=0 and op_cnt=0 next edge, overriding en_rsa and rst_rsa.

Configuration
REQ-027 SHALL, with RSA_SKIP_LEADING_ZEROS_EN defined, start bit_idx in LOAD at the most-significant set bit of exp_i and skip the first square (first op is a multiply).
REQ-028 SHALL, without RSA_SKIP_LEADING_ZEROS_EN, start bit_idx at WIDTH-1 with full square count (constant-time behaviour).

Structure
REQ-029 SHALL place the state enum and the SQUARE/MULTIPLY mm_sel constants in the shared package rsa_pkg.
REQ-030 SHALL place the leading-one detector in sub-module rsa_lead_one, instantiated only under RSA_SKIP_LEADING_ZEROS_EN.

Verification
REQ-031 SHALL cover: WIDTH=8, exp_i=8'h05, no macro, mm_done 3 cycles after each mm_start -> 8 squares, 2 multiplies (after bit-2 and bit-0 squares), op_cnt=10, eoc_int=1.
REQ-032 SHALL cover: same stimulus with RSA_SKIP_LEADING_ZEROS_EN -> multiply, square, square, multiply; op_cnt=4.
REQ-033 SHALL cover: exp_i=8'h00 -> ld_one pulse, no mm_start, eoc_int=1 two cycles after leaving IDLE, op_cnt=0.
REQ-034 SHALL cover: en_rsa=0 for 5 cycles inside SQ_WAIT with mm_done pulsed while frozen -> state unchanged and pulse ignored; resumes on the next mm_done.
REQ-035 SHALL cover: rst_rsa=0 during MUL_WAIT of exp_i=8'hFF -> IDLE next cycle, op_cnt=0; a later mm_done produces no mm_start.
REQ-036 SHALL cover: rst=1 asserted in DONE -> eoc_int=0 next edge even with en_rsa=0.

Source files
------------

// File: rtl/rsa_pkg.sv
// rsa_pkg: types and constants shared by the RSA exponent sequencer.
//   rsa_state_e          - sequencer state encoding
//   MM_SQUARE/MM_MULTIPLY - values driven on mm_sel
package rsa_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD     = 3'd1,
    SQ_REQ   = 3'd2,
    SQ_WAIT  = 3'd3,
    MUL_REQ  = 3'd4,
    MUL_WAIT = 3'd5,
    NEXT     = 3'd6,
    DONE     = 3'd7
  } rsa_state_e;

  localparam logic MM_SQUARE   = 1'b0;
  localparam logic MM_MULTIPLY = 1'b1;

endpackage

// File: rtl/rsa_lead_one.sv
// rsa_lead_one: leading-one detector.
//   vec_i [WIDTH-1:0]         - input vector
//   idx_o [$clog2(WIDTH)-1:0] - index of the most-significant set bit (0 when vec_i is 0)
// Only instantiated when RSA_SKIP_LEADING_ZEROS_EN is defined.
module rsa_lead_one #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0]         vec_i,
  output logic [$clog2(WIDTH)-1:0] idx_o
);

  localparam int IW = $clog2(WIDTH);

  // Scan upward so the highest set bit is the last one to win.
  always_comb begin
    idx_o = {IW{1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      idx_o = vec_i[i] ? IW'(i) : idx_o;
    end
  end

endmodule

// File: rtl/rsa_exp_seq.sv
// rsa_exp_seq: control sequencer for left-to-right square-and-multiply
// modular exponentiation. Drives an external Montgomery multiplier.
//   clk, rst  - clock, synchronous active-high reset
//   en_rsa    - enable; 0 freezes all state
//   rst_rsa   - active-low sequence clear (1 = run)
//   exp_i     - exponent, captured in LOAD
//   mm_done   - multiplier completion pulse
//   ld_one    - pulse: load accumulator with 1
//   mm_start  - pulse: multiplier request; mm_sel 0 = square, 1 = multiply by base
//   bit_idx   - exponent bit currently processed
//   op_cnt    - multiplier operations issued since LOAD
//   eoc_int   - end of exponentiation (level)
// Optional build macro: RSA_SKIP_LEADING_ZEROS_EN - start at the most-significant
// set exponent bit and skip the initial square of 1.
// Pulses (ld_one, mm_start) are registered and appear in the cycle after the
// state that issues them; mm_done in that same cycle is therefore ignored.
module rsa_exp_seq
  import rsa_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en_rsa,
  input  logic                       rst_rsa,
  input  logic [WIDTH-1:0]           exp_i,
  input  logic                       mm_done,
  output logic                       ld_one,
  output logic                       mm_start,
  output logic                       mm_sel,
  output logic [$clog2(WIDTH)-1:0]   bit_idx,
  output logic [$clog2(2*WIDTH):0]   op_cnt,
  output logic                       eoc_int
);

  localparam int IW = $clog2(WIDTH);
  localparam int CW = $clog2(2*WIDTH) + 1;
  localparam logic [IW-1:0] IDX_ZERO = {IW{1'b0}};
  localparam logic [IW-1:0] IDX_ONE  = {{(IW-1){1'b0}}, 1'b1};
  localparam logic [IW-1:0] IDX_TOP  = IW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

  rsa_state_e        state_q, state_d;
  logic [WIDTH-1:0]  exp_q, exp_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              sel_q, sel_d;
  logic              eoc_q, eoc_d;
  logic              ld_one_q, ld_one_d;
  logic              mm_start_q, mm_start_d;
  logic [IW-1:0]     start_idx_s;
  rsa_state_e        first_op_s;
  logic              done_ok_s;

`ifdef RSA_SKIP_LEADING_ZEROS_EN
  rsa_lead_one #(.WIDTH(WIDTH)) u_lead_one (
    .vec_i (exp_i),
    .idx_o (start_idx_s)
  );
  // Accumulator is 1, so squaring it first is wasted work.
  assign first_op_s = MUL_REQ;
`else
  assign start_idx_s = IDX_TOP;
  assign first_op_s  = SQ_REQ;
`endif

  // A completion in the same cycle as the request pulse is not a real completion.
  assign done_ok_s = mm_done & ~mm_start_q;

  // Next-state and next-output computation.
  always_comb begin
    state_d    = state_q;
    exp_d      = exp_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    sel_d      = sel_q;
    eoc_d      = eoc_q;
    ld_one_d   = 1'b0;
    mm_start_d = 1'b0;
    if (!en_rsa) begin
      // Frozen: hold everything, pulses forced low.
      state_d = state_q;
    end else if (!rst_rsa) begin
      state_d = IDLE;
      idx_d   = IDX_ZERO;
      cnt_d   = CNT_ZERO;
      sel_d   = MM_SQUARE;
      eoc_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: state_d = LOAD;
        LOAD: begin
          exp_d    = exp_i;
          ld_one_d = 1'b1;
          idx_d    = start_idx_s;
          cnt_d    = CNT_ZERO;
          state_d  = (~|exp_i) ? DONE : first_op_s;
        end
        SQ_REQ: begin
          mm_start_d = 1'b1;
          sel_d      = MM_SQUARE;
          cnt_d      = cnt_q + CNT_ONE;
          state_d    = SQ_WAIT;
        end
        SQ_WAIT: begin
          if (done_ok_s) begin
            state_d = exp_q[idx_q] ? MUL_REQ : NEXT;
          end else begin
            state_d = SQ_WAIT;
          end
        end
        MUL_REQ: begin
          mm_start_d = 1'b1;
          sel_d      = MM_MULTIPLY;
          cnt_d      = cnt_q + CNT_ONE;
          state_d    = MUL_WAIT;
        end
        MUL_WAIT: begin
          if (done_ok_s) begin
            state_d = NEXT;
          end else begin
            state_d = MUL_WAIT;
          end
        end
        NEXT: begin
          if (idx_q == IDX_ZERO) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q - IDX_ONE;
            state_d = SQ_REQ;
          end
        end
        DONE:    state_d = DONE;
        default: state_d = IDLE;
      endcase
      // eoc rises the cycle after DONE is entered, then holds while in DONE.
      eoc_d = (state_q == DONE);
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      exp_q      <= {WIDTH{1'b0}};
      idx_q      <= IDX_ZERO;
      cnt_q      <= CNT_ZERO;
      sel_q      <= MM_SQUARE;
      eoc_q      <= 1'b0;
      ld_one_q   <= 1'b0;
      mm_start_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      exp_q      <= exp_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      sel_q      <= sel_d;
      eoc_q      <= eoc_d;
      ld_one_q   <= ld_one_d;
      mm_start_q <= mm_start_d;
    end
  end

  assign ld_one   = ld_one_q;
  assign mm_start = mm_start_q;
  assign mm_sel   = sel_q;
  assign bit_idx  = idx_q;
  assign op_cnt   = cnt_q;
  assign eoc_int  = eoc_q;

endmodule

// File: tb/tb_rsa_exp_seq.sv
// tb_rsa_exp_seq: self-checking bench for rsa_exp_seq (WIDTH=8).
// Reference: expected multiplier operation list derived from the exponent bits.
module tb_rsa_exp_seq;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             en_rsa = 1'b0;
  logic             rst_rsa = 1'b0;
  logic [WIDTH-1:0] exp_i = '0;
  logic             mm_done = 1'b0;
  logic             ld_one, mm_start, mm_sel, eoc_int;
  logic [2:0]       bit_idx;
  logic [4:0]       op_cnt;

  int checks = 0;
  int failures = 0;
  bit exp_ops[$];

  rsa_exp_seq #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .en_rsa(en_rsa), .rst_rsa(rst_rsa), .exp_i(exp_i),
    .mm_done(mm_done), .ld_one(ld_one), .mm_start(mm_start), .mm_sel(mm_sel),
    .bit_idx(bit_idx), .op_cnt(op_cnt), .eoc_int(eoc_int)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Operation list: 0 = square, 1 = multiply.
  task automatic model_ops(input logic [WIDTH-1:0] e);
    int top;
    exp_ops.delete();
    if (e != 0) begin
      top = WIDTH - 1;
`ifdef RSA_SKIP_LEADING_ZEROS_EN
      while (!e[top]) top--;
      exp_ops.push_back(1'b1);
      for (int i = top - 1; i >= 0; i--) begin
        exp_ops.push_back(1'b0);
        if (e[i]) exp_ops.push_back(1'b1);
      end
`else
      for (int i = top; i >= 0; i--) begin
        exp_ops.push_back(1'b0);
        if (e[i]) exp_ops.push_back(1'b1);
      end
`endif
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full exponentiation with a multiplier responding lat cycles after each request.
  task automatic run_exp(input logic [WIDTH-1:0] e, input int lat, input bit echo, input string tag);
    int cd, ld_cnt, ld_cyc, eoc_cyc, sel_bad, nmin;
    bit cur_sel;
    bit obs_ops[$];
    model_ops(e);
    en_rsa = 1'b1; rst_rsa = 1'b0; mm_done = 1'b0;
    tick();
    rst_rsa = 1'b1; exp_i = e;
    cd = -1; ld_cnt = 0; ld_cyc = -1; eoc_cyc = -1; sel_bad = 0; cur_sel = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      tick();
      mm_done = 1'b0;
      if (ld_one) begin ld_cnt++; ld_cyc = cyc; end
      if (eoc_int) begin eoc_cyc = cyc; break; end
      if (mm_start) begin
        obs_ops.push_back(mm_sel);
        cur_sel = mm_sel;
        cd = lat;
        if (echo) mm_done = 1'b1;
      end else if (cd > 0) begin
        if (mm_sel !== cur_sel) sel_bad++;
        cd--;
        if (cd == 0) begin mm_done = 1'b1; cd = -1; end
      end
    end
    check({tag, "_finished"}, eoc_cyc >= 0, 1);
    check({tag, "_ld_one_count"}, ld_cnt, 1);
    check({tag, "_ld_one_cycle"}, ld_cyc, 1);
    check({tag, "_ops_len"}, obs_ops.size(), exp_ops.size());
    nmin = (obs_ops.size() < exp_ops.size()) ? obs_ops.size() : exp_ops.size();
    for (int i = 0; i < nmin; i++) check({tag, "_op_kind"}, obs_ops[i], exp_ops[i]);
    check({tag, "_sel_held"}, sel_bad, 0);
    check({tag, "_op_cnt"}, op_cnt, exp_ops.size());
    if (e != 0) check({tag, "_bit_idx_end"}, bit_idx, 0);
    if (e == 0) check({tag, "_eoc_cycle"}, eoc_cyc, 2);
    tick();
    check({tag, "_eoc_held"}, eoc_int, 1);
    check({tag, "_done_quiet"}, {mm_start, ld_one}, 0);
  endtask

  initial begin
    int cnt0, idx0, sel0, bad, found, cd;

    // Reset overrides enable and run.
    rst = 1'b1; en_rsa = 1'b1; rst_rsa = 1'b1;
    repeat (3) tick();
    check("reset_outputs", {ld_one, mm_start, mm_sel, eoc_int}, 0);
    check("reset_bit_idx", bit_idx, 0);
    check("reset_op_cnt", op_cnt, 0);
    rst = 1'b0;

    run_exp(8'h05, 3, 1'b0, "exp05");
    run_exp(8'h00, 3, 1'b0, "exp00");
    run_exp(8'h80, 1, 1'b1, "exp80");
    run_exp(8'hFF, 2, 1'b1, "expFF");
    for (int r = 0; r < 6; r++) begin
      run_exp(WIDTH'($urandom), $urandom_range(1, 4), 1'($urandom_range(0, 1)), "rand");
    end

    // Freeze inside the first wait; a pulse while frozen must be ignored.
    model_ops(8'hA5);
    rst_rsa = 1'b0; en_rsa = 1'b1; tick();
    rst_rsa = 1'b1; exp_i = 8'hA5;
    found = 0;
    for (int i = 0; i < 20; i++) begin tick(); if (mm_start) begin found = 1; break; end end
    check("frz_first_req", found, 1);
    cnt0 = op_cnt; idx0 = bit_idx; sel0 = mm_sel;
    en_rsa = 1'b0; bad = 0;
    for (int i = 0; i < 5; i++) begin
      mm_done = (i == 2);
      tick();
      mm_done = 1'b0;
      if (mm_start || ld_one || eoc_int) bad++;
      if (op_cnt !== cnt0 || bit_idx !== idx0 || mm_sel !== sel0) bad++;
    end
    check("frz_hold", bad, 0);
    en_rsa = 1'b1; bad = 0;
    for (int i = 0; i < 3; i++) begin tick(); if (mm_start) bad++; end
    check("frz_pulse_ignored", bad, 0);
    check("frz_op_cnt", op_cnt, cnt0);
    mm_done = 1'b1; tick(); mm_done = 1'b0;
    found = 0;
    for (int i = 0; i < 6; i++) begin if (mm_start) begin found = 1; break; end tick(); end
    check("frz_resume_req", found, 1);
    check("frz_resume_cnt", op_cnt, cnt0 + 1);
    check("frz_resume_sel", mm_sel, exp_ops[1]);

    // Abort during a multiply wait of exponent FF.
    rst_rsa = 1'b0; tick();
    rst_rsa = 1'b1; exp_i = 8'hFF;
    found = 0; cd = -1;
    for (int i = 0; i < 40; i++) begin
      tick();
      mm_done = 1'b0;
      if (mm_start && mm_sel) begin found = 1; break; end
      if (mm_start) cd = 2;
      else if (cd > 0) begin cd--; if (cd == 0) begin mm_done = 1'b1; cd = -1; end end
    end
    check("abort_mul_wait_reached", found, 1);
    rst_rsa = 1'b0; tick();
    check("abort_op_cnt", op_cnt, 0);
    check("abort_bit_idx", bit_idx, 0);
    check("abort_eoc", eoc_int, 0);
    mm_done = 1'b1; tick(); mm_done = 1'b0;
    bad = 0;
    for (int i = 0; i < 5; i++) begin tick(); if (mm_start || ld_one) bad++; end
    check("abort_late_done_ignored", bad, 0);

    // Reset in DONE with the sequencer frozen.
    run_exp(8'h03, 2, 1'b0, "exp03");
    en_rsa = 1'b0; rst = 1'b1; tick();
    check("rst_in_done_eoc", eoc_int, 0);
    check("rst_in_done_cnt", op_cnt, 0);
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
